// File: rtl/updi_pkg.sv
// rtl/updi_pkg.sv - shared UPDI opcode, byte and state definitions
package updi_pkg;

  // Opcode class in bits [7:5] of the instruction byte
  localparam logic [2:0] OP_LDS    = 3'b000;
  localparam logic [2:0] OP_LD     = 3'b001;
  localparam logic [2:0] OP_STS    = 3'b010;
  localparam logic [2:0] OP_ST     = 3'b011;
  localparam logic [2:0] OP_LDCS   = 3'b100;
  localparam logic [2:0] OP_REPEAT = 3'b101;
  localparam logic [2:0] OP_STCS   = 3'b110;
  localparam logic [2:0] OP_KEY    = 3'b111;

  localparam logic [7:0] SYNC_VALUE = 8'h55;
  localparam logic [7:0] ACK_VALUE  = 8'h40;

  localparam logic [3:0] CS_STATUSA = 4'h0;
  localparam logic [3:0] CS_CTRLB   = 4'h3;

  typedef enum logic [3:0] {
    HUNT_SYNC,
    GET_OPCODE,
    GET_ADDR_LO,
    GET_ADDR_HI,
    SEND_CS,
    GET_CS_DATA,
    MEM_READ,
    MEM_WAIT,
    SEND_DATA,
    SEND_ACK_ADDR,
    GET_DATA,
    MEM_WRITE,
    SEND_ACK_DATA
  } resp_state_e;

endpackage

// File: rtl/updi_cs_regfile.sv
// rtl/updi_cs_regfile.sv - 16x8 control/status registers, address 0 read-only
module updi_cs_regfile
  import updi_pkg::*;
#(
  parameter logic [7:0] STATUSA_VALUE = 8'h30
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       we,
  input  logic [3:0] waddr,
  input  logic [7:0] wdata,
  input  logic [3:0] raddr,
  output logic [7:0] rdata
);

  logic [7:0] regs_q [16];

  // Register array; break clears everything, entry 0 is never written
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      for (int i = 0; i < 16; i++) regs_q[i] <= '0;
    end else if (we && (waddr != CS_STATUSA)) begin
      regs_q[waddr] <= wdata;
    end
  end

  // Asynchronous read; STATUSA is a fixed revision value
  always_comb begin
    rdata = regs_q[raddr];
    if (raddr == CS_STATUSA) rdata = STATUSA_VALUE;
  end

endmodule

// File: rtl/updi_target_responder.sv
// rtl/updi_target_responder.sv - UPDI target: parses RX instruction stream, services CS and memory
module updi_target_responder
  import updi_pkg::*;
#(
  parameter logic [7:0] STATUSA_VALUE = 8'h30,
  parameter logic [7:0] ACK_BYTE      = ACK_VALUE
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_empty,
  output logic        rx_rd_en,
  output logic [7:0]  tx_data,
  output logic        tx_wr_en,
  input  logic        tx_full,
  input  logic        break_in,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  output logic        mem_we,
  output logic        mem_re,
  input  logic [7:0]  mem_rdata,
  output logic        busy,
  output logic        proto_error
);

  resp_state_e state_q, state_d;
  logic [15:0] addr_q;
  logic [7:0]  data_q;
  logic [3:0]  cs_addr_q;
  logic        word_q;
  logic        store_q;
  logic [7:0]  cs_rdata;

  logic consuming, sending, pop, push;
  logic op_ld_st, op_ok;
  resp_state_e after_addr;

  assign consuming = (state_q == HUNT_SYNC) || (state_q == GET_OPCODE) ||
                     (state_q == GET_ADDR_LO) || (state_q == GET_ADDR_HI) ||
                     (state_q == GET_CS_DATA) || (state_q == GET_DATA);
  assign sending   = (state_q == SEND_CS) || (state_q == SEND_DATA) ||
                     (state_q == SEND_ACK_ADDR) || (state_q == SEND_ACK_DATA);
  // Break suppresses any pop or push in its cycle
  assign pop  = consuming && !rx_empty && !break_in;
  assign push = sending && !tx_full && !break_in;

  // LDS/STS allow byte or word address and byte data only
  assign op_ld_st = (rx_data[7:5] == OP_LDS) || (rx_data[7:5] == OP_STS);
  assign op_ok    = (rx_data[7:5] == OP_LDCS) || (rx_data[7:5] == OP_STCS) ||
                    (op_ld_st && !rx_data[3] && (rx_data[1:0] == 2'b00));
  assign after_addr = store_q ? SEND_ACK_ADDR : MEM_READ;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= HUNT_SYNC;
    else     state_q <= state_d;
  end

  // Next-state logic; break wins over every other event
  always_comb begin
    state_d = state_q;
    if (break_in) begin
      state_d = HUNT_SYNC;
    end else begin
      case (state_q)
        HUNT_SYNC:     if (pop && (rx_data == SYNC_VALUE)) state_d = GET_OPCODE;
        GET_OPCODE: begin
          if (pop) begin
            if (!op_ok)                          state_d = HUNT_SYNC;
            else if (rx_data[7:5] == OP_LDCS)    state_d = SEND_CS;
            else if (rx_data[7:5] == OP_STCS)    state_d = GET_CS_DATA;
            else                                 state_d = GET_ADDR_LO;
          end
        end
        GET_ADDR_LO:   if (pop) state_d = word_q ? GET_ADDR_HI : after_addr;
        GET_ADDR_HI:   if (pop) state_d = after_addr;
        SEND_CS:       if (push) state_d = HUNT_SYNC;
        GET_CS_DATA:   if (pop) state_d = HUNT_SYNC;
        MEM_READ:      state_d = MEM_WAIT;
        MEM_WAIT:      state_d = SEND_DATA;
        SEND_DATA:     if (push) state_d = HUNT_SYNC;
        SEND_ACK_ADDR: if (push) state_d = GET_DATA;
        GET_DATA:      if (pop) state_d = MEM_WRITE;
        MEM_WRITE:     state_d = SEND_ACK_DATA;
        SEND_ACK_DATA: if (push) state_d = HUNT_SYNC;
        default:       state_d = HUNT_SYNC;
      endcase
    end
  end

  // Outputs decoded from state, latches and FIFO flags
  always_comb begin
    rx_rd_en    = pop;
    tx_wr_en    = push;
    mem_re      = (state_q == MEM_READ) && !break_in;
    mem_we      = (state_q == MEM_WRITE) && !break_in;
    proto_error = (state_q == GET_OPCODE) && pop && !op_ok;
    busy        = (state_q != HUNT_SYNC);
    case (state_q)
      SEND_CS:                      tx_data = cs_rdata;
      SEND_DATA:                    tx_data = data_q;
      SEND_ACK_ADDR, SEND_ACK_DATA: tx_data = ACK_BYTE;
      default:                      tx_data = 8'h00;
    endcase
  end

  assign mem_addr  = addr_q;
  assign mem_wdata = data_q;

  // Opcode fields, address and data latches
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q    <= '0;
      data_q    <= '0;
      cs_addr_q <= '0;
      word_q    <= 1'b0;
      store_q   <= 1'b0;
    end else begin
      if (pop && (state_q == GET_OPCODE)) begin
        cs_addr_q <= rx_data[3:0];
        word_q    <= rx_data[2];
        store_q   <= (rx_data[7:5] == OP_STS);
      end
      if (pop && (state_q == GET_ADDR_LO)) addr_q <= {8'h00, rx_data};
      if (pop && (state_q == GET_ADDR_HI)) addr_q[15:8] <= rx_data;
      if ((state_q == MEM_WAIT) && !break_in) data_q <= mem_rdata;
      if (pop && (state_q == GET_DATA)) data_q <= rx_data;
    end
  end

  updi_cs_regfile #(
    .STATUSA_VALUE(STATUSA_VALUE)
  ) u_cs_regfile (
    .clk  (clk),
    .rst  (rst),
    .clr  (break_in),
    .we   (pop && (state_q == GET_CS_DATA)),
    .waddr(cs_addr_q),
    .wdata(rx_data),
    .raddr(cs_addr_q),
    .rdata(cs_rdata)
  );

endmodule

// File: tb/tb_updi_target_responder.sv
// tb/tb_updi_target_responder.sv - directed self-checking bench for updi_target_responder
module tb_updi_target_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_empty;
  logic        rx_rd_en;
  logic [7:0]  tx_data;
  logic        tx_wr_en;
  logic        tx_full;
  logic        break_in;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_we;
  logic        mem_re;
  logic [7:0]  mem_rdata;
  logic        busy;
  logic        proto_error;

  int total = 0;
  int bad = 0;

  logic [7:0] rx_mem [256];
  int rx_head = 0;
  int rx_tail = 0;
  logic [7:0] tx_log [256];
  int tx_cnt = 0;
  int we_cnt = 0;
  int re_cnt = 0;
  int proto_cnt = 0;
  logic [15:0] we_addr, re_addr;
  logic [7:0]  we_data;
  logic [7:0]  mem_model [0:65535];

  updi_target_responder dut (
    .clk(clk), .rst(rst),
    .rx_data(rx_data), .rx_empty(rx_empty), .rx_rd_en(rx_rd_en),
    .tx_data(tx_data), .tx_wr_en(tx_wr_en), .tx_full(tx_full),
    .break_in(break_in),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
    .mem_rdata(mem_rdata),
    .busy(busy), .proto_error(proto_error)
  );

  always #5 clk = ~clk;

  assign rx_empty = (rx_head == rx_tail);
  assign rx_data  = rx_mem[rx_head[7:0]];

  // FIFO, memory and event monitors
  always @(posedge clk) begin
    if (rx_rd_en) rx_head <= rx_head + 1;
    if (tx_wr_en && !tx_full) begin
      tx_log[tx_cnt[7:0]] <= tx_data;
      tx_cnt <= tx_cnt + 1;
    end
    if (mem_we) begin
      we_cnt <= we_cnt + 1;
      we_addr <= mem_addr;
      we_data <= mem_wdata;
    end
    if (mem_re) begin
      re_cnt <= re_cnt + 1;
      re_addr <= mem_addr;
      mem_rdata <= mem_model[mem_addr];
    end
    if (proto_error) proto_cnt <= proto_cnt + 1;
  end

  task automatic push_byte(input logic [7:0] b);
    rx_mem[rx_tail[7:0]] = b;
    rx_tail = rx_tail + 1;
  endtask

  task automatic wait_idle(input int max, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (rx_empty && !busy) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_tx(input int target, input int max, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (tx_cnt >= target) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; tx_full = 1'b0; break_in = 1'b0; mem_rdata = 8'h00;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    total++;
    if (busy !== 1'b0) begin $display("FAIL reset_busy got=%b want=0", busy); bad++; end
    total++;
    if ({rx_rd_en, tx_wr_en, mem_we, mem_re, proto_error} !== 5'b0) begin
      $display("FAIL reset_strobes got=%b want=00000", {rx_rd_en, tx_wr_en, mem_we, mem_re, proto_error}); bad++;
    end
    total++;
    if ({mem_addr, mem_wdata, tx_data} !== 32'h0) begin
      $display("FAIL reset_buses got=%h want=00000000", {mem_addr, mem_wdata, tx_data}); bad++;
    end
    @(negedge clk);
  endtask

  task automatic test_ldcs_statusa;
    int t0;
    bit ok;
    t0 = tx_cnt;
    push_byte(8'h55); push_byte(8'h80);
    wait_idle(50, ok);
    total++;
    if (!ok) begin $display("FAIL ldcs_idle got=timeout want=idle"); bad++; end
    total++;
    if (tx_cnt - t0 !== 1) begin $display("FAIL ldcs_count got=%0d want=1", tx_cnt - t0); bad++; end
    total++;
    if (tx_log[t0[7:0]] !== 8'h30) begin $display("FAIL ldcs_byte got=%h want=30", tx_log[t0[7:0]]); bad++; end
  endtask

  task automatic test_stcs_ldcs;
    int t0;
    bit ok;
    t0 = tx_cnt;
    push_byte(8'h55); push_byte(8'hC2); push_byte(8'h5A);
    wait_idle(50, ok);
    total++;
    if (!ok || (tx_cnt !== t0)) begin $display("FAIL stcs_silent got=%0d want=0 ok=%0d", tx_cnt - t0, ok); bad++; end
    push_byte(8'h55); push_byte(8'h82);
    wait_idle(50, ok);
    total++;
    if (!ok || (tx_cnt - t0 !== 1)) begin $display("FAIL ldcs2_count got=%0d want=1", tx_cnt - t0); bad++; end
    total++;
    if (tx_log[t0[7:0]] !== 8'h5A) begin $display("FAIL ldcs2_byte got=%h want=5a", tx_log[t0[7:0]]); bad++; end
  endtask

  task automatic test_sts;
    int t0, w0;
    bit ok;
    t0 = tx_cnt; w0 = we_cnt;
    push_byte(8'h55); push_byte(8'h44); push_byte(8'h34); push_byte(8'h12);
    wait_tx(t0 + 1, 50, ok);
    total++;
    if (!ok || (tx_log[t0[7:0]] !== 8'h40)) begin $display("FAIL sts_ack1 got=%h want=40", tx_log[t0[7:0]]); bad++; end
    total++;
    if (we_cnt !== w0) begin $display("FAIL sts_early_we got=%0d want=0", we_cnt - w0); bad++; end
    push_byte(8'hAB);
    wait_idle(50, ok);
    total++;
    if (!ok || (we_cnt - w0 !== 1)) begin $display("FAIL sts_we_count got=%0d want=1", we_cnt - w0); bad++; end
    total++;
    if ({we_addr, we_data} !== 24'h1234AB) begin $display("FAIL sts_we_bus got=%h want=1234ab", {we_addr, we_data}); bad++; end
    total++;
    if ((tx_cnt - t0 !== 2) || (tx_log[(t0 + 1) & 255] !== 8'h40)) begin
      $display("FAIL sts_ack2 got=%h cnt=%0d want=40 cnt=2", tx_log[(t0 + 1) & 255], tx_cnt - t0); bad++;
    end
  endtask

  task automatic test_lds_backpressure;
    int t0, r0, unstable;
    bit ok;
    t0 = tx_cnt; r0 = re_cnt; unstable = 0;
    mem_model[16'h0010] = 8'hC7;
    tx_full = 1'b1;
    push_byte(8'h55); push_byte(8'h00); push_byte(8'h10);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (re_cnt != r0) begin ok = 1'b1; break; end
    end
    total++;
    if (!ok || (re_addr !== 16'h0010)) begin $display("FAIL lds_re got=%h want=0010 ok=%0d", re_addr, ok); bad++; end
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if ((tx_data !== 8'hC7) || (tx_wr_en !== 1'b0)) unstable++;
    end
    total++;
    if (unstable != 0 || tx_cnt !== t0) begin $display("FAIL lds_hold got=%0d want=0 data=%h", unstable, tx_data); bad++; end
    tx_full = 1'b0;
    wait_idle(50, ok);
    total++;
    if (!ok || (tx_cnt - t0 !== 1) || (tx_log[t0[7:0]] !== 8'hC7)) begin
      $display("FAIL lds_data got=%h cnt=%0d want=c7 cnt=1", tx_log[t0[7:0]], tx_cnt - t0); bad++;
    end
  endtask

  task automatic test_proto_error;
    int t0, p0;
    bit ok;
    t0 = tx_cnt; p0 = proto_cnt;
    push_byte(8'h00); push_byte(8'h55); push_byte(8'h20);
    wait_idle(50, ok);
    total++;
    if (!ok || (proto_cnt - p0 !== 1)) begin $display("FAIL proto_pulse got=%0d want=1", proto_cnt - p0); bad++; end
    total++;
    if (tx_cnt !== t0) begin $display("FAIL proto_silent got=%0d want=0", tx_cnt - t0); bad++; end
    push_byte(8'h55); push_byte(8'h80);
    wait_idle(50, ok);
    total++;
    if (!ok || (tx_cnt - t0 !== 1) || (tx_log[t0[7:0]] !== 8'h30)) begin
      $display("FAIL proto_recover got=%h want=30", tx_log[t0[7:0]]); bad++;
    end
  endtask

  task automatic test_back_to_back;
    int t0;
    bit ok;
    t0 = tx_cnt;
    push_byte(8'h55); push_byte(8'h80); push_byte(8'h55); push_byte(8'h80);
    wait_idle(50, ok);
    total++;
    if (!ok || (tx_cnt - t0 !== 2) || (tx_log[t0[7:0]] !== 8'h30) || (tx_log[(t0 + 1) & 255] !== 8'h30)) begin
      $display("FAIL b2b got_cnt=%0d want=2", tx_cnt - t0); bad++;
    end
  endtask

  task automatic test_break;
    int t0, w0, p0;
    bit ok;
    push_byte(8'h55); push_byte(8'hC2); push_byte(8'h5A);
    wait_idle(50, ok);
    t0 = tx_cnt; w0 = we_cnt; p0 = proto_cnt;
    tx_full = 1'b1;
    push_byte(8'h55); push_byte(8'h44); push_byte(8'h34); push_byte(8'h12);
    repeat (8) @(negedge clk);
    break_in = 1'b1;
    @(negedge clk);
    break_in = 1'b0;
    #1;
    total++;
    if (busy !== 1'b0) begin $display("FAIL break_hunt got=%b want=0", busy); bad++; end
    tx_full = 1'b0;
    push_byte(8'hAB);
    repeat (10) @(negedge clk);
    total++;
    if ((we_cnt !== w0) || (tx_cnt !== t0)) begin
      $display("FAIL break_abort got_we=%0d got_tx=%0d want=0", we_cnt - w0, tx_cnt - t0); bad++;
    end
    push_byte(8'h55);
    @(negedge clk);
    push_byte(8'h80);
    break_in = 1'b1;
    #1;
    total++;
    if (rx_rd_en !== 1'b0) begin $display("FAIL break_no_pop got=%b want=0", rx_rd_en); bad++; end
    @(negedge clk);
    break_in = 1'b0;
    wait_idle(50, ok);
    total++;
    if (!ok || (tx_cnt !== t0) || (proto_cnt !== p0)) begin
      $display("FAIL break_opcode_drop got_tx=%0d got_proto=%0d want=0", tx_cnt - t0, proto_cnt - p0); bad++;
    end
    push_byte(8'h55); push_byte(8'h82);
    wait_idle(50, ok);
    total++;
    if (!ok || (tx_cnt - t0 !== 1) || (tx_log[t0[7:0]] !== 8'h00)) begin
      $display("FAIL break_cs_clear got=%h want=00", tx_log[t0[7:0]]); bad++;
    end
  endtask

  initial begin
    test_reset;
    test_ldcs_statusa;
    test_stcs_ldcs;
    test_sts;
    test_lds_backpressure;
    test_proto_error;
    test_back_to_back;
    test_break;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/updi_target_responder.md
Name: updi_target_responder

Overview:
- Device-side (responder) end of the UPDI link: a UPDI target model that answers the programmer's instruction stream.
- Consumes bytes from a UART RX FIFO, parses SYNC, opcode, address and data, and services the request.
- Services reads/writes of a 16-entry control/status (CS) register file and an external byte-wide memory port; pushes responses (read data, ACK) into a UART TX FIFO.
- Used as the loop-back target in system simulation and as an FPGA-hosted target emulator.

Parameters:
STATUSA_VALUE, 8'h30, read-only value returned for CS address 0x0 (UPDI revision 3)
ACK_BYTE, 8'h40, acknowledge byte sent by STS

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
rx_data  in  8  RX FIFO head byte (first-word-fall-through, valid while !rx_empty)
rx_empty  in  1  RX FIFO empty
rx_rd_en  out  1  pop RX FIFO head
tx_data  out  8  byte to TX FIFO
tx_wr_en  out  1  push tx_data
tx_full  in  1  TX FIFO full
break_in  in  1  one-cycle pulse from PHY on detected break
mem_addr  out  16  memory address
mem_wdata  out  8  memory write data
mem_we  out  1  one-cycle write strobe
mem_re  out  1  one-cycle read strobe
mem_rdata  in  8  read data, valid exactly 1 cycle after mem_re
busy  out  1  high whenever state != HUNT_SYNC
proto_error  out  1  one-cycle pulse on protocol violation

Behaviour:
- Reset: state HUNT_SYNC; all outputs 0; CS regs 1..15 = 0; addr/data latches = 0.
- RX pop rule: rx_rd_en = 1 only in a byte-consuming state with !rx_empty; the byte is consumed in that same cycle. One byte per cycle max.
- TX push rule: tx_wr_en = 1 only in a send state with !tx_full; the state advances in that cycle. While tx_full is high, hold state with tx_data stable.
- Opcode decode, bits [7:5]:
  - 100 LDCS: CS address = op[3:0].
  - 110 STCS: CS address = op[3:0].
  - 000 LDS / 010 STS: op[3:2] = address size (00 byte, 01 word); op[1:0] = data size, only 00 supported.
  - Any other opcode, address size 1x, or data size != 00: pulse proto_error, return to HUNT_SYNC.
- States:
  - HUNT_SYNC: pop bytes; 0x55 -> GET_OPCODE; any other byte is discarded silently.
  - GET_OPCODE: pop and decode.
    - LDCS -> SEND_CS.
    - STCS -> GET_CS_DATA.
    - LDS/STS -> GET_ADDR_LO.
  - GET_ADDR_LO: pop and latch addr[7:0].
    - Byte address size: addr[15:8] = 0, go to next phase.
    - Word address size -> GET_ADDR_HI.
  - GET_ADDR_HI: pop and latch addr[15:8].
  - Next phase after the address: LDS -> MEM_READ; STS -> SEND_ACK_ADDR.
  - SEND_CS: tx_data = STATUSA_VALUE if address 0, else cs[addr]; push, then HUNT_SYNC.
  - GET_CS_DATA: pop byte into cs[addr]; writes to address 0 are ignored; no response; then HUNT_SYNC.
  - MEM_READ: mem_re = 1 with mem_addr = latched address -> MEM_WAIT.
  - MEM_WAIT: capture mem_rdata -> SEND_DATA.
  - SEND_DATA: push captured byte -> HUNT_SYNC.
  - SEND_ACK_ADDR: push ACK_BYTE -> GET_DATA.
  - GET_DATA: pop byte into data latch -> MEM_WRITE.
  - MEM_WRITE: mem_we = 1, mem_addr/mem_wdata = latches -> SEND_ACK_DATA.
  - SEND_ACK_DATA: push ACK_BYTE -> HUNT_SYNC.
- LDS latency: mem_re fires 1 cycle after the last address byte is popped; tx push happens at the earliest 3 cycles after that pop.
- Break handling (break_in):
  - Takes priority over every other event in the same cycle, including a pop or push.
  - State -> HUNT_SYNC; no mem_we/mem_re/tx_wr_en/rx_rd_en in that cycle.
  - CS regs 1..15 clear to 0.
  - An STS aborted before MEM_WRITE performs no write.
  - No proto_error is raised.
- rx_empty during any consuming state: wait indefinitely; there is no timeout.
- Outputs rx_rd_en, tx_wr_en, mem_we, mem_re and mem_* are combinational from state and latches.

Decomposition:
- Shared package updi_pkg:
  - opcode field constants (LDS/STS/LDCS/STCS/LD/ST/REPEAT/KEY);
  - SYNC (0x55) and ACK (0x40) constants;
  - CS address constants (STATUSA = 0x0, CTRLB = 0x3);
  - the responder state enum.
- One natural sub-module, updi_cs_regfile: 16x8 registers, write port, async read port, address 0 read-only returning STATUSA_VALUE, clear on rst or break.

Test Plan:
- Push 0x55, 0x80 -> exactly one tx byte, 0x30; busy returns low.
- Push 0x55 0xC2 0x5A, then 0x55 0x82 -> no tx byte for the STCS; tx 0x5A for the LDCS.
- Push 0x55 0x44 0x34 0x12 -> tx 0x40; then 0xAB -> one mem_we pulse with addr 0x1234, wdata 0xAB; then tx 0x40.
- Memory model returns 0xC7 at 0x0010; push 0x55 0x00 0x10 -> mem_re with addr 0x0010, then tx 0xC7. Hold tx_full high 5 cycles -> push delayed, byte unchanged.
- Push 0x00 0x55 0x20 -> 0x00 ignored; proto_error pulse on 0x20; following 0x55 0x80 -> tx 0x30.
- Push 0x55 0x44 0x34 0x12, pulse break_in during the ACK wait (tx_full held) -> no mem_we, no tx; a CS reg previously set to 0x5A reads back 0x00.
